// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB PWM generator: channel indices and default sizing.
package rgb_pwm_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned PRESCALE_DEF = 187;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;
  localparam logic [1:0] CH_ALL   = 2'd3;

  // True when a write addressed to chan targets channel idx (CH_ALL hits every channel).
  function automatic logic chan_sel(input logic [1:0] chan, input logic [1:0] idx);
    return (chan == CH_ALL) || (chan == idx);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, commit stepper and registered compare output.
// RGB_PWM_FADE_EN: commit steps active one count toward shadow instead of jumping to it.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [PWM_BITS-1:0] i_level,
  input  logic                i_commit,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] r_active;
  logic                r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow <= i_level;
      end
      // Commit reads the pre-write shadow, so a same-cycle write waits one period.
      if (i_commit) begin
`ifdef RGB_PWM_FADE_EN
        if (r_active < r_shadow) begin
          r_active <= r_active + 1'b1;
        end else if (r_active > r_shadow) begin
          r_active <= r_active - 1'b1;
        end
`else
        r_active <= r_shadow;
`endif
      end
      r_pwm <= (i_cnt < r_active);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB PWM source for the LED driver macro: prescaler, period counter, commit strobe and
// write handshake; per-channel duty lives in pwm_channel. Honours RGB_PWM_FADE_EN.
module rgb_pwm_gen
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned PRESCALE = PRESCALE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [1:0]          wr_chan,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                period_start
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     r_prescale;
  logic [PWM_BITS-1:0] r_cnt;
  logic                r_ready;
  logic                r_period_start;

  logic       w_tick;
  logic       w_commit;
  logic       w_accept;
  logic [2:0] w_pwm;

  assign w_tick   = (r_prescale == PS_MAX);
  assign w_commit = w_tick && (r_cnt == '1);
  assign w_accept = wr_valid && r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale     <= '0;
      r_cnt          <= '0;
      r_ready        <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_ready        <= 1'b1;
      r_period_start <= w_commit;
      if (w_tick) begin
        r_prescale <= '0;
        r_cnt      <= r_cnt + 1'b1;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept && chan_sel(wr_chan, 2'(g))),
      .i_level (wr_level),
      .i_commit(w_commit),
      .i_cnt   (r_cnt),
      .o_pwm   (w_pwm[g])
    );
  end

  assign wr_ready     = r_ready;
  assign period_start = r_period_start;
  assign pwm_r        = w_pwm[CH_RED];
  assign pwm_g        = w_pwm[CH_GREEN];
  assign pwm_b        = w_pwm[CH_BLUE];

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Bench for rgb_pwm_gen: cycle-indexed behavioural model checked every cycle, plus
// directed period-level duty counts and a randomized write/reset phase.
module tb_rgb_pwm_gen;

  localparam int P   = 2;
  localparam int PER = 256 * P;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_chan;
  logic [7:0] wr_level;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  rgb_pwm_gen #(
    .PWM_BITS(8),
    .PRESCALE(P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_chan     (wr_chan),
    .wr_level    (wr_level),
    .pwm_r       (pwm_r),
    .pwm_g       (pwm_g),
    .pwm_b       (pwm_b),
    .period_start(period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int step(input int act, input int sh);
`ifdef RGB_PWM_FADE_EN
    if (act < sh) return act + 1;
    if (act > sh) return act - 1;
    return act;
`else
    return sh;
`endif
  endfunction

  // Model: m_t is the cycle index since reset release; counter and wrap follow from it.
  int m_t;
  int m_sh[3];
  int m_act[3];
  bit m_pwm[3];
  bit m_ps;
  bit m_ready;
  bit m_valid = 1'b0;

  initial begin
    int  cnt;
    bit  commit;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t = 0;
        m_ps = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          m_sh[i] = 0;
          m_act[i] = 0;
          m_pwm[i] = 1'b0;
        end
      end else begin
        cnt    = (m_t / P) % 256;
        commit = (m_t % PER) == PER - 1;
        for (int i = 0; i < 3; i++) m_pwm[i] = cnt < m_act[i];
        m_ps = commit;
        if (commit) begin
          for (int i = 0; i < 3; i++) m_act[i] = step(m_act[i], m_sh[i]);
        end
        if (wr_valid && m_ready) begin
          for (int i = 0; i < 3; i++) begin
            if (wr_chan == 2'd3 || int'(wr_chan) == i) m_sh[i] = int'(wr_level);
          end
        end
        m_ready = 1'b1;
        m_t++;
      end
      m_valid = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model_pwm_r", int'(pwm_r), int'(m_pwm[0]));
        chk("model_pwm_g", int'(pwm_g), int'(m_pwm[1]));
        chk("model_pwm_b", int'(pwm_b), int'(m_pwm[2]));
        chk("model_period_start", int'(period_start), int'(m_ps));
        chk("model_wr_ready", int'(wr_ready), int'(m_ready));
      end
    end
  end

  // Called at a negedge; holds the write for exactly one sampling edge.
  task automatic do_write(input logic [1:0] ch, input int lvl);
    wr_valid = 1'b1;
    wr_chan  = ch;
    wr_level = lvl[7:0];
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * PER + 10; i++) begin
      @(negedge clk);
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("period_start_timeout", int'(seen), 1);
  endtask

  // Window of one period, starting the cycle after a period_start is observed.
  task automatic count_period(output int cr, output int cg, output int cb);
    cr = 0;
    cg = 0;
    cb = 0;
    repeat (PER) begin
      @(negedge clk);
      cr += int'(pwm_r);
      cg += int'(pwm_g);
      cb += int'(pwm_b);
    end
  endtask

  initial begin
    int n;
    int cr, cg, cb;
    bit ps_seen;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_chan  = 2'd0;
    wr_level = 8'd0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_wr_ready", int'(wr_ready), 0);
      chk("reset_pwm", int'(pwm_r | pwm_g | pwm_b), 0);
    end
    rst = 1'b0;

    n = 0;
    ps_seen = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ready_after_release", int'(wr_ready), 1);
      if (period_start) begin
        ps_seen = 1'b1;
        break;
      end
    end
    chk("first_period_start_seen", int'(ps_seen), 1);
    chk("first_period_start_cycle", n, PER);

`ifndef RGB_PWM_FADE_EN
    do_write(2'd0, 64);
    wait_ps();
    count_period(cr, cg, cb);
    chk("basic_r_128", cr, 128);
    chk("basic_g_0", cg, 0);
    chk("basic_b_0", cb, 0);

    do_write(2'd3, 255);
    wait_ps();
    count_period(cr, cg, cb);
    chk("all255_r", cr, 510);
    chk("all255_g", cg, 510);
    chk("all255_b", cb, 510);

    do_write(2'd3, 0);
    wait_ps();
    count_period(cr, cg, cb);
    chk("all0_sum", cr + cg + cb, 0);

    do_write(2'd1, 10);
    wait_ps();
    repeat (PER - 1) @(negedge clk);
    do_write(2'd1, 200);
    chk("commit_edge_ps", int'(period_start), 1);
    count_period(cr, cg, cb);
    chk("commit_edge_g_old", cg, 20);
    count_period(cr, cg, cb);
    chk("commit_edge_g_new", cg, 400);
`else
    do_write(2'd2, 5);
    wait_ps();
    for (int i = 1; i <= 6; i++) begin
      count_period(cr, cg, cb);
      chk("fade_up_b", cb, (i > 5 ? 5 : i) * P);
    end
    do_write(2'd2, 3);
    for (int i = 0; i < 3; i++) begin
      count_period(cr, cg, cb);
      chk("fade_down_b", cb, (5 - i) * P);
    end
`endif

    do_write(2'd3, 128);
    wait_ps();
    repeat (100) @(negedge clk);
    chk("mid_period_r_high", int'(pwm_r), 1);
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_chan  = 2'd0;
    wr_level = 8'd77;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("mid_reset_pwm_low", int'(pwm_r | pwm_g | pwm_b), 0);
    chk("mid_reset_ready_low", int'(wr_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (2 * PER) begin
      @(negedge clk);
      n += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
    end
    chk("after_reset_dark", n, 0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 799) == 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_chan  = 2'($urandom_range(0, 3));
      wr_level = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
